// File: rtl/logic_gate_pipe.sv
// logic_gate_pipe: NUM_IN-lane bitwise reducer, two registered stages, valid/ready.
// Ports: clk, rst_n, in_data/in_op/in_valid/in_ready, out_data/out_zero/out_ones/out_valid/out_ready, out_count.
module logic_gate_pipe #(
  parameter int WIDTH   = 8,
  parameter int NUM_IN  = 4,
  parameter int COUNT_W = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [2:0]              in_op,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_zero,
  output logic                    out_ones,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [COUNT_W-1:0]      out_count
);

  logic [WIDTH-1:0] red_and;
  logic [WIDTH-1:0] red_or;
  logic [WIDTH-1:0] red_xor;
  logic [WIDTH-1:0] lane0;
  logic [WIDTH-1:0] base_n;
  logic             inv_n;

  logic             v1;
  logic [WIDTH-1:0] base1;
  logic             inv1;
  logic             v2;
  logic [WIDTH-1:0] s2_val;

  logic ready2;
  logic accept;
  logic move;

  assign lane0 = in_data[WIDTH-1:0];

  always_comb begin
    red_and = '1;
    red_or  = '0;
    red_xor = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      red_and = red_and & in_data[k*WIDTH +: WIDTH];
      red_or  = red_or  | in_data[k*WIDTH +: WIDTH];
      red_xor = red_xor ^ in_data[k*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    base_n = lane0;
    inv_n  = 1'b0;
    unique case (1'b1)
      (in_op == 3'd0) || (in_op == 3'd3): base_n = red_and;
      (in_op == 3'd1) || (in_op == 3'd4): base_n = red_or;
      (in_op == 3'd2) || (in_op == 3'd5): base_n = red_xor;
      default:                            base_n = lane0;
    endcase
    inv_n = (in_op == 3'd3) || (in_op == 3'd4) ||
            (in_op == 3'd5) || (in_op == 3'd7);
  end

  // ready path depends on out_ready and state only
  assign ready2   = !v2 || out_ready;
  assign in_ready = !v1 || ready2;
  assign accept   = in_valid && in_ready;
  assign move     = v1 && ready2;

  assign s2_val    = base1 ^ {WIDTH{inv1}};
  assign out_valid = v2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1    <= 1'b0;
      base1 <= '0;
      inv1  <= 1'b0;
    end else begin
      if (accept) begin
        v1    <= 1'b1;
        base1 <= base_n;
        inv1  <= inv_n;
      end else if (move) begin
        v1 <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2       <= 1'b0;
      out_data <= '0;
      out_zero <= 1'b0;
      out_ones <= 1'b0;
    end else begin
      if (move) begin
        v2       <= 1'b1;
        out_data <= s2_val;
        out_zero <= (s2_val == '0);
        out_ones <= (&s2_val);
      end else if (out_ready) begin
        v2 <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_count <= '0;
    end else if (v2 && out_ready) begin
      out_count <= out_count + COUNT_W'(1);
    end
  end

endmodule
